// File: rtl/dlbf_data_pkg.sv
// dlbf_data_pkg: shared state encoding and widths
// for the BRAM-to-AXI4-Stream data master.
package dlbf_data_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  localparam int BLK_W   = 12;
  localparam int ITER_W  = 12;
  localparam int STALL_W = 32;

endpackage

// File: rtl/dlbf_data_sync_fifo.sv
// dlbf_data_sync_fifo: synchronous first-word
// fall-through FIFO holding {tlast, tdata} beats.
module dlbf_data_sync_fifo #(
  parameter int WIDTH = 65,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clr,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           rd_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty,
  output logic                       full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_C = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt;
  logic             do_wr;
  logic             do_rd;

  assign empty   = (cnt == '0);
  assign full    = (cnt == FULL_C);
  assign count   = cnt;
  assign rd_data = mem[rd_ptr];
  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && !empty;

  // storage array, written at the tail
  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // pointers and occupancy; flushed by reset or clear
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_wr) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_rd) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      unique case ({do_wr, do_rd})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/dlbf_data_axis_master.sv
// dlbf_data_axis_master: streams BRAM rows onto AXI4-Stream.
// Optional stall counter: define DLBF_AXIS_STALL_CNT_EN.
module dlbf_data_axis_master
  import dlbf_data_pkg::*;
#(
  parameter int DATA_WIDTH  = 64,
  parameter int ADDR_WIDTH  = 16,
  parameter int RAM_LATENCY = 2,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                  m_axis_aclk,
  input  logic                  m_axis_aresetn,
  input  logic                  go,
  input  logic                  m_axis_rst,
  input  logic [BLK_W-1:0]      block_size,
  input  logic [ITER_W-1:0]     niter,
  input  logic [ADDR_WIDTH-1:0] rollover_addr,
  output logic                  enb,
  output logic [ADDR_WIDTH-1:0] addrb,
  input  logic [DATA_WIDTH-1:0] doutb,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic                  m_done,
  output logic [STALL_W-1:0]    stall_cnt
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW:0] DEPTH_C = (CW + 1)'(FIFO_DEPTH);
  localparam logic [CW-1:0] ONE_C = CW'(1);

  state_t state;
  state_t state_nx;

  logic                   srst;
  logic                   go_q;
  logic                   go_rise;
  logic                   cfg_zero;
  logic [BLK_W-1:0]       bs_q;
  logic [ITER_W-1:0]      ni_q;
  logic [ADDR_WIDTH-1:0]  ro_q;
  logic [ADDR_WIDTH-1:0]  addr_q;
  logic [BLK_W-1:0]       beat_cnt;
  logic [ITER_W-1:0]      iter_cnt;
  logic [RAM_LATENCY-1:0] vld_pipe;
  logic [RAM_LATENCY-1:0] last_pipe;
  logic [CW-1:0]          inflight;
  logic [CW-1:0]          fifo_count;
  logic                   fifo_empty;
  logic                   fifo_full;
  logic [DATA_WIDTH:0]    fifo_head;
  logic                   credit_ok;
  logic                   issue;
  logic                   tlast_flag;
  logic                   final_rd;
  logic                   land;
  logic                   pop;
  logic                   last_pop;

  assign srst     = !m_axis_aresetn || m_axis_rst;
  assign go_rise  = go && !go_q;
  assign cfg_zero = (block_size == '0) || (niter == '0);

  assign credit_ok = (({1'b0, fifo_count} + {1'b0, inflight}) < DEPTH_C)
                     && !fifo_full;
  assign issue      = (state == RUN) && credit_ok;
  assign tlast_flag = (beat_cnt == bs_q - BLK_W'(1));
  assign final_rd   = tlast_flag && (iter_cnt == ni_q - ITER_W'(1));
  assign land       = vld_pipe[RAM_LATENCY-1];
  assign pop        = !fifo_empty && m_axis_tready;
  // all reads are issued in DRAIN, so one beat left means the final one
  assign last_pop   = pop && (fifo_count == ONE_C) && (inflight == '0);

  // go edge detector; only a hard reset clears the history
  always_ff @(posedge m_axis_aclk) begin
    if (!m_axis_aresetn) begin
      go_q <= 1'b0;
    end else begin
      go_q <= go;
    end
  end

  // state register
  always_ff @(posedge m_axis_aclk) begin
    if (srst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // next-state logic
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (go_rise) begin
          state_nx = cfg_zero ? DONE : RUN;
        end
      end
      RUN: begin
        if (issue && final_rd) begin
          state_nx = DRAIN;
        end
      end
      DRAIN: begin
        if (last_pop) begin
          state_nx = DONE;
        end
      end
      DONE: begin
        if (!go) begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // shadow copies of the run configuration, frozen at the go edge
  always_ff @(posedge m_axis_aclk) begin
    if (srst) begin
      bs_q <= '0;
      ni_q <= '0;
      ro_q <= '0;
    end else if (state == IDLE && go_rise) begin
      bs_q <= block_size;
      ni_q <= niter;
      ro_q <= rollover_addr;
    end
  end

  // address and block counters, advanced per issued read
  // rollover 0 makes ro_q-1 all ones, giving the natural wrap
  always_ff @(posedge m_axis_aclk) begin
    if (srst || (state == IDLE && go_rise)) begin
      addr_q   <= '0;
      beat_cnt <= '0;
      iter_cnt <= '0;
    end else if (issue) begin
      addr_q   <= (addr_q == ro_q - ADDR_WIDTH'(1)) ? '0
                  : addr_q + ADDR_WIDTH'(1);
      beat_cnt <= tlast_flag ? '0 : beat_cnt + BLK_W'(1);
      iter_cnt <= tlast_flag ? iter_cnt + ITER_W'(1) : iter_cnt;
    end
  end

  // read-latency delay line carrying valid and tlast per read
  always_ff @(posedge m_axis_aclk) begin
    if (srst) begin
      vld_pipe  <= '0;
      last_pipe <= '0;
    end else begin
      vld_pipe[0]  <= issue;
      last_pipe[0] <= tlast_flag;
      for (int i = 1; i < RAM_LATENCY; i++) begin
        vld_pipe[i]  <= vld_pipe[i-1];
        last_pipe[i] <= last_pipe[i-1];
      end
    end
  end

  // reads issued but not yet written into the FIFO
  always_ff @(posedge m_axis_aclk) begin
    if (srst) begin
      inflight <= '0;
    end else begin
      unique case ({issue, land})
        2'b10:   inflight <= inflight + ONE_C;
        2'b01:   inflight <= inflight - ONE_C;
        default: inflight <= inflight;
      endcase
    end
  end

  dlbf_data_sync_fifo #(
    .WIDTH (DATA_WIDTH + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (m_axis_aclk),
    .rst_n   (m_axis_aresetn),
    .clr     (m_axis_rst),
    .wr_en   (land),
    .wr_data ({last_pipe[RAM_LATENCY-1], doutb}),
    .rd_en   (pop),
    .rd_data (fifo_head),
    .count   (fifo_count),
    .empty   (fifo_empty),
    .full    (fifo_full)
  );

  assign enb           = issue;
  assign addrb         = addr_q;
  assign m_axis_tvalid = !fifo_empty;
  assign m_axis_tdata  = fifo_head[DATA_WIDTH-1:0];
  assign m_axis_tlast  = !fifo_empty && fifo_head[DATA_WIDTH];
  assign m_done        = (state == DONE);

`ifdef DLBF_AXIS_STALL_CNT_EN
  logic [STALL_W-1:0] stall_q;

  // saturating count of cycles with tvalid held against !tready
  always_ff @(posedge m_axis_aclk) begin
    if (srst || go_rise) begin
      stall_q <= '0;
    end else if (m_axis_tvalid && !m_axis_tready && stall_q != '1) begin
      stall_q <= stall_q + STALL_W'(1);
    end
  end

  assign stall_cnt = stall_q;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_dlbf_data_axis_master.sv
// tb_dlbf_data_axis_master: directed bench for the
// BRAM-to-AXI4-Stream master with a 2-cycle BRAM model.
module tb_dlbf_data_axis_master;

  logic        clk = 1'b0;
  logic        aresetn;
  logic        go;
  logic        srst;
  logic [11:0] block_size;
  logic [11:0] niter;
  logic [15:0] rollover;
  logic        enb;
  logic [15:0] addrb;
  logic [63:0] doutb;
  logic [63:0] tdata;
  logic        tvalid;
  logic        tready;
  logic        tlast;
  logic        m_done;
  logic [31:0] stall_cnt;

  int total = 0;
  int bad = 0;

  logic [63:0] mem [2048];
  logic [63:0] p0;
  logic [63:0] p1;

  logic [63:0] beats_d [$];
  logic        beats_l [$];
  int          beats_c [$];
  logic [15:0] addrs [$];
  int          stalls;
  int          done_cyc;
  int          viol;
  int          hs;

  always #5 clk = ~clk;

  dlbf_data_axis_master dut (
    .m_axis_aclk    (clk),
    .m_axis_aresetn (aresetn),
    .go             (go),
    .m_axis_rst     (srst),
    .block_size     (block_size),
    .niter          (niter),
    .rollover_addr  (rollover),
    .enb            (enb),
    .addrb          (addrb),
    .doutb          (doutb),
    .m_axis_tdata   (tdata),
    .m_axis_tvalid  (tvalid),
    .m_axis_tready  (tready),
    .m_axis_tlast   (tlast),
    .m_done         (m_done),
    .stall_cnt      (stall_cnt)
  );

  always @(posedge clk) begin
    if (enb) p0 <= mem[addrb[10:0]];
    p1 <= p0;
  end
  assign doutb = p1;

  function automatic logic [63:0] row(input logic [15:0] a);
    return {16'hD1B0, a, ~a, a ^ 16'h5A5A};
  endfunction

  task automatic check(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic go_edge();
    @(negedge clk);
    go = 1'b1;
    @(posedge clk);
  endtask

  task automatic do_run(input bit rnd, input int budget);
    logic        prev_stall;
    logic [64:0] prev_out;
    beats_d.delete();
    beats_l.delete();
    beats_c.delete();
    addrs.delete();
    stalls = 0;
    done_cyc = -1;
    prev_stall = 1'b0;
    prev_out = '0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (m_done) begin
        done_cyc = c;
        break;
      end
      if (prev_stall) check("stall_hold", {tvalid, tlast, tdata},
                            {1'b1, prev_out});
      tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (enb) addrs.push_back(addrb);
      if (tvalid && tready) begin
        beats_d.push_back(tdata);
        beats_l.push_back(tlast);
        beats_c.push_back(c);
      end
      prev_stall = tvalid && !tready;
      prev_out = {tlast, tdata};
      if (prev_stall) stalls++;
    end
    tready = 1'b1;
    check("run_done_in_budget", done_cyc >= 0, 1);
  endtask

  task automatic check_beats(input string tag, input int n,
                             input int bs, input int ro);
    check({tag, "_count"}, beats_d.size(), n);
    for (int k = 0; k < beats_d.size() && k < n; k++) begin
      check({tag, "_data"}, beats_d[k], row(16'(k % ro)));
      check({tag, "_last"}, beats_l[k], (k % bs) == bs - 1);
    end
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) mem[i] = row(16'(i));
    aresetn = 1'b0;
    go = 1'b0;
    srst = 1'b0;
    tready = 1'b1;
    block_size = 12'd4;
    niter = 12'd3;
    rollover = 16'd1536;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_outputs", {enb, addrb, tvalid, tlast, m_done, stall_cnt},
          '0);
    aresetn = 1'b1;
    repeat (2) @(negedge clk);

    // 1: basic run, with CSR inputs scrambled after the go edge
    go_edge();
    #1;
    block_size = 12'd7;
    niter = 12'd1;
    rollover = 16'd3;
    do_run(1'b0, 100);
    check_beats("basic", 12, 4, 1536);
    if (beats_c.size() == 12) begin
      check("basic_first_cyc", beats_c[0], 3);
      check("basic_back2back", beats_c[11] - beats_c[0], 11);
      check("basic_done_cyc", done_cyc, beats_c[11] + 1);
    end
    check("basic_stall_cnt", stall_cnt, 0);
    @(negedge clk);
    go = 1'b0;
    @(negedge clk);
    check("basic_done_clr", m_done, 0);

    // 2: rollover at 5 rows inside one 8-beat block
    block_size = 12'd8;
    niter = 12'd1;
    rollover = 16'd5;
    go_edge();
    do_run(1'b0, 100);
    check_beats("roll", 8, 8, 5);
    check("roll_addr_count", addrs.size(), 8);
    for (int k = 0; k < addrs.size() && k < 8; k++)
      check("roll_addr", addrs[k], 16'(k % 5));
    @(negedge clk);
    go = 1'b0;
    @(negedge clk);

    // 3: random backpressure over a long run
    block_size = 12'd384;
    niter = 12'd4;
    rollover = 16'd1536;
    go_edge();
    do_run(1'b1, 8000);
    check_beats("bp", 1536, 384, 1536);
    check("bp_some_stalls", stalls > 0, 1);
`ifdef DLBF_AXIS_STALL_CNT_EN
    check("bp_stall_cnt", stall_cnt, stalls);
`else
    check("bp_stall_cnt", stall_cnt, 0);
`endif
    @(negedge clk);
    go = 1'b0;
    @(negedge clk);

    // 4: zero iterations completes with no beats
    block_size = 12'd4;
    niter = 12'd0;
    go_edge();
    do_run(1'b0, 10);
    check("zero_no_beats", beats_d.size(), 0);
    check("zero_no_reads", addrs.size(), 0);
    check("zero_done_fast", done_cyc <= 1, 1);
    @(negedge clk);
    go = 1'b0;
    @(negedge clk);

    // 5: soft reset after 5 beats, then a clean restart
    niter = 12'd3;
    go_edge();
    hs = 0;
    for (int c = 0; c < 40 && hs < 5; c++) begin
      @(negedge clk);
      if (tvalid && tready) hs++;
    end
    check("srst_reached_beat5", hs, 5);
    srst = 1'b1;
    @(negedge clk);
    check("srst_outputs", {tvalid, m_done, enb, addrb}, '0);
    srst = 1'b0;
    go = 1'b0;
    @(negedge clk);
    check("srst_idle_quiet", {tvalid, enb}, 2'b00);
    go_edge();
    do_run(1'b0, 100);
    check_beats("restart", 12, 4, 1536);
    if (addrs.size() > 0) check("restart_addr0", addrs[0], 0);

    // 6: go held high keeps DONE; low then high re-arms
    viol = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (!m_done || tvalid || enb) viol++;
    end
    check("hold_go_no_rerun", viol, 0);
    go = 1'b0;
    @(negedge clk);
    check("rearm_done_low", m_done, 0);
    go_edge();
    do_run(1'b0, 100);
    check_beats("rearm", 12, 4, 1536);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
